// File: rtl/inc_sinc_pkg.sv
// Shared types and sizing helpers for the incremental sinc decimator.
package inc_sinc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Final integrator of an ORDER-stage cascade over 2^osr_log2 samples fits here.
  function automatic int acc_width(input int order, input int osr_log2);
    return order * osr_log2 + 1;
  endfunction

endpackage

// File: rtl/inc_sinc_spi_readout.sv
// Serial readout of the latest result: synchronised sclk/cs_n, MSB-first shifter.
module inc_sinc_spi_readout #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic [OUT_W-1:0] load_data,
  output logic             serial_data_out
);

  // Bits [1:0] are the synchroniser, bit [2] is the previous synced value.
  logic [2:0]       sclk_sync;
  logic [2:0]       cs_sync;
  logic [OUT_W-1:0] shreg;
  logic             cs_fall;
  logic             sclk_fall;
  logic             cs_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs_n};
    end
  end

  assign cs_fall   = cs_sync[2] & ~cs_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign cs_active = ~cs_sync[1];

  // Loading happens only on the cs_n fall, so a result landing mid-frame is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (cs_fall) begin
      shreg <= load_data;
    end else if (cs_active && sclk_fall) begin
      shreg <= {shreg[OUT_W-2:0], 1'b0};
    end
  end

  assign serial_data_out = cs_active & shreg[OUT_W-1];

endmodule

// File: rtl/inc_sinc_decimator.sv
// Incremental-ADC decimator: ORDER-stage integrator cascade over 2^OSR_LOG2 bits,
// scaled and saturated to OUT_W, with parallel and serial readout.
module inc_sinc_decimator
  import inc_sinc_pkg::*;
#(
  parameter int ORDER    = 2,
  parameter int OSR_LOG2 = 9,
  parameter int OUT_W    = 12,
  parameter int SHIFT    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             new_data,
  output logic             busy,
  output logic             overflow,
  input  logic             sclk,
  input  logic             cs_n,
  output logic             serial_data_out
);

  localparam int ACC_W = acc_width(ORDER, OSR_LOG2);
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [EXT_W-1:0] MAX_OUT = EXT_W'((64'd1 << OUT_W) - 64'd1);

  state_t              state;
  logic [OSR_LOG2-1:0] count;
  logic                launch;
  logic [ACC_W-1:0]    final_acc;
  logic [EXT_W-1:0]    scaled;
  logic                saturate;

  assign launch = (state == IDLE) && (start || continuous);

  // Combinational cascade: stage k adds the already-updated stage k-1.
  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    if (k == 0) begin : g_first
      assign acc_next = acc + ACC_W'(data_in);
    end else begin : g_cascade
      assign acc_next = acc + g_stage[k-1].acc_next;
    end

    always_ff @(posedge clk) begin
      if (!rst_n || launch) begin
        acc <= '0;
      end else if (state == CONV) begin
        acc <= acc_next;
      end
    end
  end

  assign final_acc = g_stage[ORDER-1].acc;
  assign scaled    = EXT_W'(final_acc) >> SHIFT;
  assign saturate  = scaled > MAX_OUT;

  // Continuous restarts pass back through IDLE, giving an N+2 cycle period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start || continuous) state <= CONV;
        CONV:    if (&count) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      count <= '0;
    end else if (state == CONV) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      overflow <= 1'b0;
      new_data <= 1'b0;
    end else begin
      new_data <= (state == DONE);
      if (state == DONE) begin
        data_out <= saturate ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
        overflow <= saturate;
      end
    end
  end

  assign busy = (state == CONV);

  inc_sinc_spi_readout #(
    .OUT_W(OUT_W)
  ) u_spi (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .cs_n           (cs_n),
    .load_data      (data_out),
    .serial_data_out(serial_data_out)
  );

endmodule

// File: tb/tb_inc_sinc_decimator.sv
// Directed bench for inc_sinc_decimator: three parameterisations share stimulus,
// results are checked against hand-computed values.
module tb_inc_sinc_decimator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic       continuous_c;
  logic       data_in;
  logic       sclk;
  logic       cs_n;

  logic [11:0] data_out_a, data_out_b, data_out_c;
  logic        new_data_a, new_data_b, new_data_c;
  logic        busy_a, busy_b, busy_c;
  logic        overflow_a, overflow_b, overflow_c;
  logic        serial_a, serial_b, serial_c;

  // A: ORDER 2, N 512, SHIFT 6
  inc_sinc_decimator #(.ORDER(2), .OSR_LOG2(9), .OUT_W(12), .SHIFT(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .continuous(1'b0), .data_in(data_in),
    .data_out(data_out_a), .new_data(new_data_a), .busy(busy_a), .overflow(overflow_a),
    .sclk(sclk), .cs_n(cs_n), .serial_data_out(serial_a));

  // B: ORDER 2, N 512, SHIFT 5 (saturates on all-ones)
  inc_sinc_decimator #(.ORDER(2), .OSR_LOG2(9), .OUT_W(12), .SHIFT(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .continuous(1'b0), .data_in(data_in),
    .data_out(data_out_b), .new_data(new_data_b), .busy(busy_b), .overflow(overflow_b),
    .sclk(1'b0), .cs_n(1'b1), .serial_data_out(serial_b));

  // C: ORDER 3, N 64, SHIFT 4
  inc_sinc_decimator #(.ORDER(3), .OSR_LOG2(6), .OUT_W(12), .SHIFT(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .continuous(continuous_c), .data_in(data_in),
    .data_out(data_out_c), .new_data(new_data_c), .busy(busy_c), .overflow(overflow_c),
    .sclk(1'b0), .cs_n(1'b1), .serial_data_out(serial_c));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nd_cnt   [3] = '{0, 0, 0};
  int busy_cnt [3] = '{0, 0, 0};
  int nd_cyc_c [$];
  logic [12:0] exp_q [$];   // {overflow, data_out} expected from dut_a, in order
  logic [12:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy_a) busy_cnt[0]++;
    if (busy_b) busy_cnt[1]++;
    if (busy_c) busy_cnt[2]++;
    if (new_data_b) nd_cnt[1]++;
    if (new_data_a) begin
      nd_cnt[0]++;
      if (exp_q.size() == 0) begin
        check("a_unexpected_new_data", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("a_data_out", data_out_a, mon_e[11:0]);
        check("a_overflow", overflow_a, mon_e[12]);
      end
    end
    if (new_data_c) begin
      nd_cnt[2]++;
      nd_cyc_c.push_back(cyc);
      check("c_data_out", data_out_c, 2860);
      check("c_overflow", overflow_c, 0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic pat_bit(input int pattern, input int k);
    case (pattern)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (k % 2 == 0);
    endcase
  endfunction

  // One conversion on DUT 'which': optional reset at sample index abort_at,
  // optional stray start pulse at sample index mid_start.
  task automatic run_conv(input int which, input int pattern, input int n,
                          input int abort_at, input int mid_start, input int exp_pulses);
    int nd0;
    nd0 = nd_cnt[which];
    busy_cnt[which] = 0;
    @(negedge clk);
    start_v[which] = 1'b1;
    @(negedge clk);
    start_v[which] = 1'b0;
    for (int k = 0; k < n; k++) begin
      data_in = pat_bit(pattern, k);
      rst_n = (k != abort_at);
      start_v[which] = (k == mid_start);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start_v[which] = 1'b0;
    data_in = 1'b0;
    for (int t = 0; t < 10 && nd_cnt[which] == nd0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check($sformatf("dut%0d_new_data_count", which), nd_cnt[which] - nd0, exp_pulses);
    if (exp_pulses == 1) check($sformatf("dut%0d_busy_cycles", which), busy_cnt[which], n);
  endtask

  task automatic spi_frame(output logic [11:0] bits);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      bits[11-i] = serial_a;
      sclk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [11:0] frame_bits;
  int          frame_nd0;

  initial begin
    rst_n = 1'b0; start_v = 3'b000; continuous_c = 1'b0;
    data_in = 1'b0; sclk = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_new_data", new_data_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_serial", serial_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy_a, 0);

    // all-ones: 512*513/2 >> 6 = 2052
    exp_q.push_back({1'b0, 12'd2052});
    run_conv(0, 1, 512, -1, -1, 1);
    // alternating 1,0: 65792 >> 6 = 1028
    exp_q.push_back({1'b0, 12'd1028});
    run_conv(0, 2, 512, -1, -1, 1);

    // SHIFT 5: 4104 saturates
    run_conv(1, 1, 512, -1, -1, 1);
    check("b_data_out_sat", data_out_b, 4095);
    check("b_overflow", overflow_b, 1);

    // Load 2052, then read it serially while an all-zeros result lands mid-frame
    exp_q.push_back({1'b0, 12'd2052});
    run_conv(0, 1, 512, -1, -1, 1);
    exp_q.push_back({1'b0, 12'd0});
    fork
      run_conv(0, 0, 512, -1, -1, 1);
      begin
        repeat (500) @(negedge clk);
        frame_nd0 = nd_cnt[0];
        spi_frame(frame_bits);
        check("spi_result_mid_frame", nd_cnt[0] - frame_nd0, 1);
      end
    join
    check("spi_frame_bits", frame_bits, 12'b100000000100);
    sclk = 1'b1; repeat (2) @(negedge clk);
    check("spi_extra_bit", serial_a, 0);
    sclk = 1'b0; repeat (2) @(negedge clk);
    cs_n = 1'b1; repeat (4) @(negedge clk);
    check("spi_cs_high", serial_a, 0);
    check("a_data_out_zero", data_out_a, 0);

    // Reset at sample 300 aborts with no result
    exp_q.push_back({1'b0, 12'd2052});
    run_conv(0, 1, 512, -1, -1, 1);
    run_conv(0, 1, 512, 299, -1, 0);
    check("abort_data_out", data_out_a, 0);
    check("abort_busy", busy_a, 0);
    // Next run correct; stray start mid-conversion ignored
    exp_q.push_back({1'b0, 12'd2052});
    run_conv(0, 1, 512, -1, 100, 1);
    repeat (20) @(negedge clk);
    check("no_restart_busy", busy_a, 0);
    check("a_queue_drained", exp_q.size(), 0);

    // Continuous mode on C: 45760 >> 4 = 2860 every 66 cycles
    data_in = 1'b1;
    continuous_c = 1'b1;
    for (int t = 0; t < 400 && nd_cyc_c.size() < 3; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    continuous_c = 1'b0;
    repeat (200) @(negedge clk);
    data_in = 1'b0;
    check("c_result_count", nd_cyc_c.size(), 4);
    for (int i = 1; i < nd_cyc_c.size(); i++)
      check($sformatf("c_period_%0d", i), nd_cyc_c[i] - nd_cyc_c[i-1], 66);
    check("c_stopped_busy", busy_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
